router_pkt_reg: RTL
===================

// Module: router_pkt_reg
// PURPOSE
// Ingress packet register in front of router_fifo. Accepts one byte per cycle from the source.
// Tracks header/payload/parity framing and forwards every byte into the FIFO through a
// one-entry output register. Generates write_enb/lfd_state/data for the FIFO and back-pressures
// the source with busy. Computes running XOR parity and flags length and parity errors.
// PARAMETERS
// DATA_W  8  byte width; header = {len[DATA_W-1:2], addr[1:0]}
// PORTS
// clk          in   1         rising-edge clock
// reset        in   1         asynchronous, active-high; clears all state
// soft_reset   in   1         synchronous flush: FSM->IDLE, output register emptied
// pkt_valid    in   1         high on header/payload bytes, low on the parity byte
// data_in      in   DATA_W    source byte
// fifo_full    in   1         router_fifo full flag
// busy         out  1         source must hold data_in/pkt_valid while high
// write_enb    out  1         FIFO write strobe
// lfd_state    out  1         high while the header byte is being written
// data_out     out  DATA_W    byte to FIFO data_in
// dest_addr    out  2         header addr of current/last packet
// parity_done  out  1         1-cycle pulse after parity byte accepted
// low_pkt_valid out 1         pkt_valid dropped before len payload bytes
// err          out  1         packet error (parity/length/addr); held until next header accepted
// BEHAVIOUR
// - Reset (either): busy=0, write_enb=0, lfd_state=0, data_out=0, dest_addr=0, parity_done=0,
//   low_pkt_valid=0, err=0, FSM=IDLE, pending=0, par=0, cnt=0. soft_reset leaves dest_addr/err.
// - Output stage: pending flag + byte reg + hdr tag. write_enb = pending & ~fifo_full (comb).
//   lfd_state = write_enb & hdr tag. busy = pending & fifo_full (comb). Never writes when full.
// - Accept: byte taken when ~busy and FSM expects a byte. Accepted byte loads the output reg,
//   pending=1. Latency: accepted in cycle N -> data_out/write_enb in N+1 (if not full).
//   If nothing accepted and ~fifo_full, pending clears. Full at accept time -> held, no loss.
// - FSM IDLE: pkt_valid=1 & ~busy -> header accepted; len=data_in[7:2], dest_addr=data_in[1:0],
//   par=data_in, cnt=0, err=0, low_pkt_valid=0 -> LOAD. pkt_valid=0 in IDLE: ignored.
// - LOAD: ~busy & pkt_valid -> payload: par^=data_in, cnt++ (saturate at 63).
//   ~busy & ~pkt_valid -> parity byte: forwarded, -> CHECK.
// - CHECK (1 cycle, busy forced 1): parity_done=1; low_pkt_valid=(cnt<len);
//   err = (par!=parity byte) | (cnt!=len) | (dest_addr==2'b11). -> IDLE.
// - len=0: parity expected directly after header. Overrun (cnt>len) still forwarded, err=1.
// - Header accepted on the cycle following CHECK is legal (back-to-back packets).
// - soft_reset mid-packet: drops pending byte (write_enb low next cycle), par/cnt cleared,
//   no parity_done. soft_reset has priority over accept in the same cycle.
// CONFIGURATION
// - PKT_REG_ERR_CNT_EN defined: extra port err_cnt out 8; +1 each CHECK with err=1,
//   saturates at 255, cleared by reset only. Undefined: port and counter absent, rest identical.
// TESTING
// - Hdr 8'h10 (len=4, addr=0), 4 payload bytes, parity=XOR of all 5, fifo_full=0:
//   6 writes, lfd_state only on write 1, parity_done once, err=0.
// - Same packet with parity byte ^8'h01 -> err=1, low_pkt_valid=0; err clears on next header.
// - Hdr len=4, pkt_valid dropped after 2 payload bytes -> low_pkt_valid=1, err=1.
// - fifo_full=1 for 3 cycles mid-payload -> busy=1 for 3 cycles, no write while full,
//   byte sequence at FIFO identical to source order, none lost or duplicated.
// - soft_reset during payload byte 2 -> FSM IDLE, write_enb=0 next cycle; next hdr 8'h05 OK.
// - With PKT_REG_ERR_CNT_EN: 3 bad-parity packets -> err_cnt=3; soft_reset keeps 3.

Source files
------------

// File: rtl/router_pkt_reg.sv
// Ingress packet register: frames header/payload/parity and forwards every byte to router_fifo
// through a one-entry output register. Define PKT_REG_ERR_CNT_EN to add the err_cnt port.
module router_pkt_reg #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              soft_reset,
   input  logic              pkt_valid,
   input  logic [DATA_W-1:0] data_in,
   input  logic              fifo_full,
   output logic              busy,
   output logic              write_enb,
   output logic              lfd_state,
   output logic [DATA_W-1:0] data_out,
   output logic [1:0]        dest_addr,
   output logic              parity_done,
   output logic              low_pkt_valid,
   output logic              err
`ifdef PKT_REG_ERR_CNT_EN
   ,
   output logic [7:0]        err_cnt
`endif
);

   localparam int LEN_W = DATA_W - 2;
   localparam logic [LEN_W-1:0] CNT_MAX = {LEN_W{1'b1}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      CHECK = 2'd2
   } state_t;

   state_t            state_r;
   logic              pending_r;
   logic              hdr_r;
   logic [DATA_W-1:0] par_r;
   logic [LEN_W-1:0]  len_r;
   logic [LEN_W-1:0]  cnt_r;
   logic              hdr_acc_s;
   logic              pay_acc_s;
   logic              par_acc_s;
   logic              accept_s;
   logic              chk_err_s;

   function automatic logic par_mismatch(input logic [DATA_W-1:0] acc,
                                         input logic [DATA_W-1:0] rx);
      return |(acc ^ rx);
   endfunction

   // FIFO handshake and byte-acceptance decode
   always_comb begin
      busy      = (pending_r & fifo_full) | (state_r == CHECK);
      write_enb = pending_r & ~fifo_full;
      lfd_state = pending_r & ~fifo_full & hdr_r;
      hdr_acc_s = 1'b0;
      pay_acc_s = 1'b0;
      par_acc_s = 1'b0;
      if (busy) begin
         hdr_acc_s = 1'b0;
      end else begin
         case (state_r)
            IDLE: hdr_acc_s = pkt_valid;
            LOAD: begin
               pay_acc_s = pkt_valid;
               par_acc_s = ~pkt_valid;
            end
            default: hdr_acc_s = 1'b0;
         endcase
      end
      accept_s  = hdr_acc_s | pay_acc_s | par_acc_s;
      // data_out still holds the parity byte during CHECK: busy blocks any new accept
      chk_err_s = par_mismatch(par_r, data_out) | (cnt_r != len_r) | (dest_addr == 2'b11);
   end

   // Framing FSM, output register and status flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r       <= IDLE;
         pending_r     <= 1'b0;
         hdr_r         <= 1'b0;
         data_out      <= {DATA_W{1'b0}};
         par_r         <= {DATA_W{1'b0}};
         len_r         <= {LEN_W{1'b0}};
         cnt_r         <= {LEN_W{1'b0}};
         dest_addr     <= 2'b00;
         parity_done   <= 1'b0;
         low_pkt_valid <= 1'b0;
         err           <= 1'b0;
`ifdef PKT_REG_ERR_CNT_EN
         err_cnt       <= 8'd0;
`endif
      end else if (soft_reset) begin
         state_r       <= IDLE;
         pending_r     <= 1'b0;
         hdr_r         <= 1'b0;
         data_out      <= {DATA_W{1'b0}};
         par_r         <= {DATA_W{1'b0}};
         len_r         <= {LEN_W{1'b0}};
         cnt_r         <= {LEN_W{1'b0}};
         parity_done   <= 1'b0;
         low_pkt_valid <= 1'b0;
      end else begin
         parity_done <= 1'b0;
         if (accept_s) begin
            pending_r <= 1'b1;
            data_out  <= data_in;
            hdr_r     <= hdr_acc_s;
         end else if (!fifo_full) begin
            pending_r <= 1'b0;
         end
         case (state_r)
            IDLE: begin
               if (hdr_acc_s) begin
                  len_r         <= data_in[DATA_W-1:2];
                  dest_addr     <= data_in[1:0];
                  par_r         <= data_in;
                  cnt_r         <= {LEN_W{1'b0}};
                  err           <= 1'b0;
                  low_pkt_valid <= 1'b0;
                  state_r       <= LOAD;
               end
            end
            LOAD: begin
               if (pay_acc_s) begin
                  par_r <= par_r ^ data_in;
                  if (cnt_r != CNT_MAX) begin
                     cnt_r <= cnt_r + LEN_W'(1);
                  end
               end else if (par_acc_s) begin
                  state_r <= CHECK;
               end
            end
            CHECK: begin
               parity_done   <= 1'b1;
               low_pkt_valid <= (cnt_r < len_r);
               err           <= chk_err_s;
`ifdef PKT_REG_ERR_CNT_EN
               if (chk_err_s && (err_cnt != 8'hFF)) begin
                  err_cnt <= err_cnt + 8'd1;
               end
`endif
               state_r       <= IDLE;
            end
            default: state_r <= IDLE;
         endcase
      end
   end

endmodule
